// File: rtl/pinball_pkg.sv
// Shared definitions for the pinball game-control and score stages.
package pinball_pkg;
  localparam int NUM_HOLES = 8;
  localparam int GROUP_W   = $clog2(NUM_HOLES);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_GET   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Isolates the lowest set bit; simultaneous holes collapse to one hit.
  function automatic logic [NUM_HOLES-1:0] lowest_onehot(input logic [NUM_HOLES-1:0] v);
    return v & (~v + {{(NUM_HOLES-1){1'b0}}, 1'b1});
  endfunction
endpackage

// File: rtl/pinball_ctrl_sync_debounce.sv
// Two-flop synchronizer plus a shared saturating stability counter over a vector.
module sync_debounce #(
  parameter int W        = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_vec_o,
  output logic         stable_o
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [W-1:0]  meta_q, sync_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      cnt_q  <= cnt_d;
    end
  end

  assign stable_vec_o = prev_q;
  assign stable_o     = (cnt_q == CNT_LAST);
endmodule

// File: rtl/pinball_ctrl.sv
// Game-control stage: conditions hole sensors and start, runs the game FSM.
//   state    | meaning
//   ST_RESET | one cycle after reset release
//   ST_WAIT  | idle, waiting for a start pulse
//   ST_START | ball in play, rotating scoring group, watching holes
//   ST_GET   | one-cycle hole hit presented to the score stage
//   ST_OVER  | game finished, timed hold before returning to WAIT
module pinball_ctrl
  import pinball_pkg::*;
#(
  parameter int BALLS      = 3,
  parameter int DEBOUNCE   = 16,
  parameter int ROT_PERIOD = 50_000_000,
  parameter int OVER_HOLD  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] hole_sensor,
  output logic [2:0] state,
  output logic [7:0] getball,
  output logic [2:0] selected_group,
  output logic [3:0] balls_left
);
  localparam int ROT_W  = $clog2(ROT_PERIOD + 1);
  localparam int OVER_W = $clog2(OVER_HOLD + 1);
  localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROT_PERIOD - 1);
  localparam logic [OVER_W-1:0] OVER_LAST = OVER_W'(OVER_HOLD - 1);

  logic st_meta_q, st_sync_q, st_prev_q, start_pulse;
  logic [NUM_HOLES-1:0] sens_vec;
  logic                 sens_stable;

  state_t               state_q, state_d;
  logic [NUM_HOLES-1:0] getball_q, getball_d;
  logic [GROUP_W-1:0]   group_q, group_d;
  logic [3:0]           balls_q, balls_d;
  logic                 armed_q, armed_d;
  logic [ROT_W-1:0]     rot_q, rot_d;
  logic [OVER_W-1:0]    over_q, over_d;

  sync_debounce #(.W(NUM_HOLES), .DEBOUNCE(DEBOUNCE)) u_sens (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_i        (hole_sensor),
    .stable_vec_o (sens_vec),
    .stable_o     (sens_stable)
  );

  assign start_pulse = st_sync_q & ~st_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_meta_q <= 1'b0;
      st_sync_q <= 1'b0;
      st_prev_q <= 1'b0;
      state_q   <= ST_RESET;
      getball_q <= '0;
      group_q   <= '0;
      balls_q   <= '0;
      armed_q   <= 1'b0;
      rot_q     <= '0;
      over_q    <= '0;
    end else begin
      st_meta_q <= start;
      st_sync_q <= st_meta_q;
      st_prev_q <= st_sync_q;
      state_q   <= state_d;
      getball_q <= getball_d;
      group_q   <= group_d;
      balls_q   <= balls_d;
      armed_q   <= armed_d;
      rot_q     <= rot_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    getball_d = getball_q;
    group_d   = group_q;
    balls_d   = balls_q;
    armed_d   = armed_q;
    rot_d     = rot_q;
    over_d    = over_q;
    case (state_q)
      ST_RESET: state_d = ST_WAIT;
      ST_WAIT: begin
        if (start_pulse) begin
          state_d = ST_START;
          balls_d = 4'(BALLS);
          armed_d = 1'b0;
          rot_d   = '0;
        end
      end
      ST_START: begin
        if (rot_q == ROT_LAST) begin
          rot_d   = '0;
          group_d = group_q + GROUP_W'(1);
        end else begin
          rot_d = rot_q + ROT_W'(1);
        end
        // Arm only after an all-clear so a ball resting in a hole is not rescored.
        if (sens_stable && (sens_vec == '0)) begin
          armed_d = 1'b1;
        end
        if (armed_q && sens_stable && (sens_vec != '0)) begin
          state_d   = ST_GET;
          getball_d = lowest_onehot(sens_vec);
        end
      end
      ST_GET: begin
        getball_d = '0;
        armed_d   = 1'b0;
        balls_d   = balls_q - 4'd1;
        if (balls_q == 4'd1) begin
          state_d = ST_OVER;
          over_d  = '0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_OVER: begin
        balls_d = '0;
        if (over_q == OVER_LAST) begin
          state_d = ST_WAIT;
        end else begin
          over_d = over_q + OVER_W'(1);
        end
      end
      default: begin
        state_d   = ST_RESET;
        getball_d = '0;
      end
    endcase
  end

  always_comb begin
    state          = state_q;
    getball        = getball_q;
    selected_group = group_q;
    balls_left     = balls_q;
  end
endmodule
